order_decode: RTL and testbench

- Receive-side counterpart of the order encoder. Accepts 64-bit AXI-Stream order frames from the MAC RX path.
- Checks the 2-beat frame format, then extracts side, order id, price and quantity into a registered valid/ready output toward strategy/book logic.
- Malformed frames are dropped and counted. The block never stalls permanently on a bad frame.

---
 rtl/order_decode.sv | 175 +++++++++++++++++
 tb/tb_order_decode.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/order_decode.sv
// Receive-side order frame decoder: validates 2-beat AXI-Stream order frames,
// presents decoded orders on a registered valid/ready port and counts good/bad frames.
//
// state   | meaning
// S_HDR   | waiting for header beat (side byte + order id)
// S_PAY   | header accepted, waiting for price/qty beat with tlast
// S_DRAIN | bad frame in progress, discarding beats up to tlast
module order_decode #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_buy,
  output logic [31:0]       out_id,
  output logic [31:0]       out_px,
  output logic [31:0]       out_qty,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  frames_ok,
  output logic [CNT_W-1:0]  frames_err
);

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_PAY   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] SIDE_BUY  = 8'h42;
  localparam logic [7:0] SIDE_SELL = 8'h53;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_live;
  logic              r_hdr_buy;
  logic [31:0]       r_hdr_id;
  logic              r_out_valid;
  logic              r_buy;
  logic [31:0]       r_id;
  logic [31:0]       r_px;
  logic [31:0]       r_qty;
  logic              r_err;
  logic [CNT_W-1:0]  r_ok_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  logic              w_tready;
  logic              w_beat;
  logic              w_out_hs;
  logic [7:0]        w_side;
  logic              w_side_ok;
  logic              w_hdr_load;
  logic              w_pay_load;
  logic              w_bad;
  logic              w_unused;

  assign w_side    = s_axis_tdata[63:56];
  assign w_side_ok = (w_side == SIDE_BUY) || (w_side == SIDE_SELL);
  assign w_unused  = ^s_axis_tdata[55:32];

  // r_live keeps tready low while held in reset; only a pending, unaccepted
  // order blocks the payload beat, so headers and drained beats always flow.
  assign w_tready = r_live && !((r_state == S_PAY) && r_out_valid && !out_ready);
  assign w_beat   = s_axis_tvalid && w_tready;
  assign w_out_hs = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_load  = 1'b0;
    w_pay_load  = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_beat) begin
          if (s_axis_tlast) begin
            w_bad = 1'b1;
          end else if (w_side_ok) begin
            w_hdr_load  = 1'b1;
            w_state_nxt = S_PAY;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_PAY: begin
        if (w_beat) begin
          if (s_axis_tlast) begin
            w_pay_load  = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_beat && s_axis_tlast) begin
          w_bad       = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HDR;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_buy <= 1'b0;
      r_hdr_id  <= 32'd0;
    end else if (w_hdr_load) begin
      r_hdr_buy <= (w_side == SIDE_BUY);
      r_hdr_id  <= s_axis_tdata[31:0];
    end
  end

  // A new payload may load on the same edge the previous order is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_buy       <= 1'b0;
      r_id        <= 32'd0;
      r_px        <= 32'd0;
      r_qty       <= 32'd0;
    end else if (w_pay_load) begin
      r_out_valid <= 1'b1;
      r_buy       <= r_hdr_buy;
      r_id        <= r_hdr_id;
      r_px        <= s_axis_tdata[63:32];
      r_qty       <= s_axis_tdata[31:0];
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_bad;
      if (w_pay_load && (r_ok_cnt != {CNT_W{1'b1}})) begin
        r_ok_cnt <= r_ok_cnt + 1'b1;
      end
      if (w_bad && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign s_axis_tready = w_tready;
  assign out_valid     = r_out_valid;
  assign out_buy       = r_buy;
  assign out_id        = r_id;
  assign out_px        = r_px;
  assign out_qty       = r_qty;
  assign err_pulse     = r_err;
  assign frames_ok     = r_ok_cnt;
  assign frames_err    = r_err_cnt;

endmodule

// File: tb/tb_order_decode.sv
// Scoreboard bench for order_decode: directed frames push expected orders,
// a monitor pops and compares on every output handshake.
module tb_order_decode;
  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          out_valid;
  logic          out_ready;
  logic          out_buy;
  logic [31:0]   out_id;
  logic [31:0]   out_px;
  logic [31:0]   out_qty;
  logic          err_pulse;
  logic [CW-1:0] frames_ok;
  logic [CW-1:0] frames_err;

  order_decode #(.DATA_W(64), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .out_valid(out_valid), .out_ready(out_ready), .out_buy(out_buy),
    .out_id(out_id), .out_px(out_px), .out_qty(out_qty),
    .err_pulse(err_pulse), .frames_ok(frames_ok), .frames_err(frames_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        buy;
    logic [31:0] id;
    logic [31:0] px;
    logic [31:0] qty;
  } order_t;

  order_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int err_cycles  = 0;
  int hs_count    = 0;
  int exp_ok      = 0;
  int exp_err     = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on each handshake and
  // checks that a stalled order holds still.
  initial begin
    order_t held;
    order_t e;
    bit     held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held_v = 1'b0;
        continue;
      end
      if (held_v)
        check("hold", {out_valid, out_buy, out_id, out_px, out_qty}, {1'b1, held});
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_order: got id %0h px %0d qty %0d, required none", out_id, out_px, out_qty);
        end else begin
          e = exp_q.pop_front();
          check("order", {out_buy, out_id, out_px, out_qty}, e);
        end
        held_v = 1'b0;
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = {out_buy, out_id, out_px, out_qty};
      end else begin
        held_v = 1'b0;
      end
      if (err_pulse) err_cycles++;
    end
  end

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic beat(input logic [63:0] d, input logic last, output int waits);
    waits = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    forever begin
      #1;
      if (s_axis_tready) begin
        @(posedge clk);
        return;
      end
      waits++;
      if (waits > 100) begin
        vectors++;
        miscompares++;
        $display("FAIL beat_timeout: tready stuck at %0b, required 1", s_axis_tready);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_order(input logic buy, input logic [31:0] id, input logic [31:0] px,
                            input logic [31:0] qty, output int stall);
    int w0, w1;
    beat({(buy ? 8'h42 : 8'h53), 24'h5A5A5A, id}, 1'b0, w0);
    beat({px, qty}, 1'b1, w1);
    exp_q.push_back({buy, id, px, qty});
    exp_ok = sat_inc(exp_ok);
    #1;
    check("latency_valid", out_valid, 1'b1);
    check("frames_ok", frames_ok, exp_ok);
    stall = w0 + w1;
  endtask

  task automatic settle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_err_pulses"}, err_cycles, exp_err);
    check({tag, "_frames_err"}, frames_err, exp_err);
    check({tag, "_frames_ok"}, frames_ok, exp_ok);
  endtask

  initial begin
    int st, st2, sum, w;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    out_ready     = 1'b0;
    #3;
    check("rst_outputs", {s_axis_tready, out_valid, err_pulse, frames_ok, frames_err, out_id, out_px},
          '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tready", s_axis_tready, 1'b1);

    // single BUY
    out_ready = 1'b1;
    send_order(1'b1, 32'd7, 32'd10050, 32'd500, st);
    idle();
    @(posedge clk);
    #1;
    check("buy_cleared", out_valid, 1'b0);

    // SELL held under backpressure, second frame stalls on its payload
    out_ready = 1'b0;
    send_order(1'b0, 32'd2, 32'd9990, 32'd100, st);
    idle();
    repeat (3) @(negedge clk);
    fork
      send_order(1'b1, 32'd3, 32'd20000, 32'd30, st2);
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    check("bp_stalled", (st2 > 0), 1'b1);
    idle();
    @(posedge clk);
    #1;
    check("bp_delivered", hs_count, 3);
    check("bp_queue_empty", exp_q.size(), 0);
    settle_check("bp");

    // bad side byte, 3-beat frame
    beat({8'h41, 24'h0, 32'd9}, 1'b0, w);
    beat(64'h1111, 1'b0, w);
    beat(64'h2222, 1'b1, w);
    exp_err++;
    idle();
    settle_check("bad_hdr");
    send_order(1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0, st);
    idle();

    // runt then oversize
    beat({8'h53, 24'h0, 32'd11}, 1'b1, w);
    exp_err++;
    beat({8'h42, 24'h0, 32'd12}, 1'b0, w);
    beat({32'd1, 32'd2}, 1'b0, w);
    beat(64'h3333, 1'b1, w);
    exp_err++;
    idle();
    settle_check("runt_over");

    // back-to-back, frames_ok saturates at CMAX
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      send_order(i[0], 32'd100 + i, 32'd1000 * (i + 1), 32'd10 + i, st);
      sum += st;
    end
    idle();
    @(posedge clk);
    #1;
    check("b2b_no_stall", sum, 0);
    check("b2b_handshakes", hs_count, 8);
    check("b2b_queue_empty", exp_q.size(), 0);

    // reset mid-frame
    beat({8'h42, 24'h0, 32'd77}, 1'b0, w);
    @(negedge clk);
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("midrst_outputs", {s_axis_tready, out_valid, err_pulse, frames_ok, frames_err, out_buy, out_qty},
          '0);
    exp_ok     = 0;
    exp_err    = 0;
    err_cycles = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tready", s_axis_tready, 1'b1);
    send_order(1'b1, 32'h12345678, 32'd55, 32'd66, st);
    idle();
    settle_check("midrst");
    check("final_queue_empty", exp_q.size(), 0);
    check("final_handshakes", hs_count, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule
